// File: rtl/cv32e40p_obi_mem_responder.sv
// OBI memory-side responder: programmable grant wait, word-addressed RAM and a
// fixed-latency, in-order response pipeline. One instance per core port.
module cv32e40p_obi_mem_responder #(
  parameter int unsigned ADDR_WIDTH      = 14,
  parameter int unsigned GNT_WAIT        = 0,
  parameter int unsigned RESP_LATENCY    = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic [3:0]  outstanding_o
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = $clog2(GNT_WAIT + 2);

  if (RESP_LATENCY < 1 || RESP_LATENCY > 8) begin : g_bad_latency
    $error("RESP_LATENCY must be in 1..8");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > RESP_LATENCY + 1) begin : g_bad_outstanding
    $error("MAX_OUTSTANDING must be in 1..RESP_LATENCY+1");
  end

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d;
  logic [3:0]              outstanding_q, outstanding_d;
  logic                    can_grant;
  logic                    gnt_fsm;
  logic                    accept;
  logic [ADDR_WIDTH-1:0]   word_idx;
  logic [31:0]             rd_word;
  logic [31:0]             mem_q [DEPTH];
  logic [RESP_LATENCY-1:0] pipe_vld_q;
  logic [RESP_LATENCY-1:0] pipe_we_q;
  logic [31:0]             pipe_data_q [RESP_LATENCY];
  logic                    unused_addr;

  // Upper address bits are dropped on purpose: the array aliases.
  assign word_idx    = addr_i[ADDR_WIDTH+1:2];
  assign unused_addr = ^{addr_i[31:ADDR_WIDTH+2], addr_i[1:0]};
  assign rd_word     = mem_q[word_idx];

  assign rvalid_o      = pipe_vld_q[RESP_LATENCY-1];
  assign rdata_o       = (rvalid_o && !pipe_we_q[RESP_LATENCY-1]) ? pipe_data_q[RESP_LATENCY-1] : 32'h0;
  assign outstanding_o = outstanding_q;

  // A response leaving this cycle frees a slot for a grant in the same cycle.
  assign can_grant = !stall_i && ((outstanding_q < 4'(MAX_OUTSTANDING)) || rvalid_o);
  assign gnt_o     = gnt_fsm && rst_ni;
  assign accept    = req_i && gnt_o;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    gnt_fsm    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_i) begin
          if (GNT_WAIT == 0) begin
            gnt_fsm = can_grant;
          end else begin
            state_d    = S_WAIT;
            wait_cnt_d = CNT_W'(1);
          end
        end
      end
      S_WAIT: begin
        if (!req_i) begin
          state_d    = S_IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == CNT_W'(GNT_WAIT)) begin
          gnt_fsm = can_grant;
          if (can_grant) begin
            state_d    = S_IDLE;
            wait_cnt_d = '0;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (accept && !rvalid_o) begin
      outstanding_d = outstanding_q + 4'd1;
    end else if (!accept && rvalid_o) begin
      outstanding_d = outstanding_q - 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      wait_cnt_q    <= '0;
      outstanding_q <= '0;
      pipe_vld_q    <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      outstanding_q <= outstanding_d;
      pipe_vld_q[0] <= accept;
      for (int i = 1; i < RESP_LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
      end
    end
  end

  // NOTE: the RAM and pipeline payload are deliberately not reset; only valid bits qualify them.
  always_ff @(posedge clk_i) begin
    pipe_we_q[0]   <= we_i;
    pipe_data_q[0] <= rd_word;
    for (int i = 1; i < RESP_LATENCY; i++) begin
      pipe_we_q[i]   <= pipe_we_q[i-1];
      pipe_data_q[i] <= pipe_data_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept && we_i) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) begin
          mem_q[word_idx][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (!rst_ni) outstanding_q <= 4'(MAX_OUTSTANDING))
    else $error("outstanding count exceeded MAX_OUTSTANDING");
`endif

endmodule

// File: tb/tb_cv32e40p_obi_mem_responder.sv
// Bench for cv32e40p_obi_mem_responder: three parameterisations checked each cycle
// against a transaction-level model (held-request count, response queue, byte memory).
module tb_cv32e40p_obi_mem_responder;

  localparam int N = 3;

  // Per-instance parameters: u0 defaults, u1 wait-state, u2 small aliased memory.
  int aw_p  [N] = '{14, 4, 4};
  int gw_p  [N] = '{0, 3, 0};
  int lat_p [N] = '{1, 2, 3};
  int mx_p  [N] = '{2, 2, 2};

  logic         clk = 1'b0;
  logic [N-1:0] rst_n, stall, req, we, gnt, rvalid;
  logic [31:0]  addr  [N];
  logic [31:0]  wdata [N];
  logic [31:0]  rdata [N];
  logic [3:0]   be    [N];
  logic [3:0]   outst [N];

  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          held    [N];
  int          max_out [N];
  int          due_q   [N][$];
  logic [31:0] dat_q   [N][$];
  int          rv_cyc  [N][$];
  logic [31:0] rv_dat  [N][$];
  logic [31:0] mem_m   [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cv32e40p_obi_mem_responder u0 (
    .clk_i(clk), .rst_ni(rst_n[0]), .stall_i(stall[0]), .req_i(req[0]), .gnt_o(gnt[0]),
    .addr_i(addr[0]), .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]),
    .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .outstanding_o(outst[0])
  );

  cv32e40p_obi_mem_responder #(
    .ADDR_WIDTH(4), .GNT_WAIT(3), .RESP_LATENCY(2), .MAX_OUTSTANDING(2)
  ) u1 (
    .clk_i(clk), .rst_ni(rst_n[1]), .stall_i(stall[1]), .req_i(req[1]), .gnt_o(gnt[1]),
    .addr_i(addr[1]), .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]),
    .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .outstanding_o(outst[1])
  );

  cv32e40p_obi_mem_responder #(
    .ADDR_WIDTH(4), .GNT_WAIT(0), .RESP_LATENCY(3), .MAX_OUTSTANDING(2)
  ) u2 (
    .clk_i(clk), .rst_ni(rst_n[2]), .stall_i(stall[2]), .req_i(req[2]), .gnt_o(gnt[2]),
    .addr_i(addr[2]), .we_i(we[2]), .be_i(be[2]), .wdata_i(wdata[2]),
    .rvalid_o(rvalid[2]), .rdata_o(rdata[2]), .outstanding_o(outst[2])
  );

  task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[u%0d] cycle %0d: got 0x%08h, want 0x%08h", name, inst, cyc, act, exp);
    end
  endtask

  // One cycle of the reference model for instance i, evaluated mid-cycle.
  task automatic model_step(input int i);
    bit          ev, eg;
    int          key;
    logic [31:0] w;
    if (!rst_n[i]) begin
      check("gnt_in_reset", i, 32'(gnt[i]), 32'h0);
      due_q[i].delete();
      dat_q[i].delete();
      held[i] = 0;
      return;
    end
    if (rvalid[i]) begin
      rv_cyc[i].push_back(cyc);
      rv_dat[i].push_back(rdata[i]);
    end
    if (32'(outst[i]) > 32'(max_out[i])) max_out[i] = int'(outst[i]);
    ev = (due_q[i].size() > 0) && (due_q[i][0] == cyc);
    eg = req[i] && (held[i] >= gw_p[i]) && !stall[i] && ((due_q[i].size() < mx_p[i]) || ev);
    check("gnt", i, 32'(gnt[i]), 32'(eg));
    check("rvalid", i, 32'(rvalid[i]), 32'(ev));
    check("outstanding", i, 32'(outst[i]), 32'(due_q[i].size()));
    if (ev) begin
      check("rdata", i, rdata[i], dat_q[i][0]);
      void'(due_q[i].pop_front());
      void'(dat_q[i].pop_front());
    end
    if (eg) begin
      key = i * 65536 + int'((addr[i] >> 2) & ((32'd1 << aw_p[i]) - 32'd1));
      w   = mem_m.exists(key) ? mem_m[key] : 32'h0;
      if (we[i]) begin
        for (int k = 0; k < 4; k++) if (be[i][k]) w[8*k +: 8] = wdata[i][8*k +: 8];
        mem_m[key] = w;
        dat_q[i].push_back(32'h0);
      end else begin
        dat_q[i].push_back(w);
      end
      due_q[i].push_back(cyc + lat_p[i]);
      held[i] = 0;
    end else if (req[i]) begin
      held[i]++;
    end else begin
      held[i] = 0;
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) model_step(i);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds a request until granted; g returns the grant cycle (-1 on timeout).
  task automatic do_txn(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input bit rs, output int g);
    int n;
    n = 0;
    g = -1;
    req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d; be[i] = b;
    while (1) begin
      if (rs) stall[i] = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (gnt[i]) begin
        g = cyc;
        break;
      end
      n++;
      if (n > 64) begin
        check("gnt_timeout", i, 32'(n), 32'h0);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    req[i] = 1'b0;
    stall[i] = 1'b0;
  endtask

  task automatic preload(input int i, input int nw);
    int g;
    for (int k = 0; k < nw; k++) do_txn(i, 1'b1, 32'(k) << 2, $urandom, 4'hF, 1'b0, g);
  endtask

  task automatic rand_phase(input int i, input int n, input int nw);
    int          g;
    logic [31:0] a, m;
    for (int k = 0; k < n; k++) begin
      tick($urandom_range(0, 2));
      m = ((32'd1 << aw_p[i]) - 32'd1) << 2;
      a = ($urandom & ~m) | (32'($urandom_range(0, nw - 1)) << 2);
      do_txn(i, 1'($urandom), a, $urandom, 4'($urandom), 1'b1, g);
    end
    tick(lat_p[i] + 2);
  endtask

  initial begin
    int s;
    int g [4];
    int exp_g  [4] = '{0, 1, 3, 4};
    int exp_rv [4] = '{3, 4, 6, 7};

    rst_n = '0; stall = '0; req = '0; we = '0;
    for (int i = 0; i < N; i++) begin
      addr[i] = '0; wdata[i] = '0; be[i] = '0; held[i] = 0; max_out[i] = 0;
    end
    tick(3);
    rst_n = '1;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check("reset_outstanding", i, 32'(outst[i]), 32'h0);
      check("reset_rvalid", i, 32'(rvalid[i]), 32'h0);
      check("reset_rdata", i, rdata[i], 32'h0);
    end
    @(posedge clk);
    #1;

    // u0: write then read back, single-cycle grant and latency
    rv_cyc[0].delete(); rv_dat[0].delete();
    s = cyc;
    do_txn(0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0, g[0]);
    do_txn(0, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0, g[1]);
    tick(1);
    check("wr_gnt_cycle", 0, 32'(g[0]), 32'(s));
    check("rd_gnt_cycle", 0, 32'(g[1]), 32'(s + 1));
    check("rv_count", 0, 32'(rv_cyc[0].size()), 32'd2);
    check("wr_rv_cycle", 0, 32'(rv_cyc[0][0]), 32'(s + 1));
    check("rd_rv_cycle", 0, 32'(rv_cyc[0][1]), 32'(s + 2));
    check("wr_rdata_zero", 0, rv_dat[0][0], 32'h0);
    check("rd_rdata", 0, rv_dat[0][1], 32'hDEADBEEF);

    // u0: byte-lane merge
    rv_cyc[0].delete(); rv_dat[0].delete();
    do_txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, g[0]);
    do_txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, g[0]);
    do_txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, g[0]);
    tick(1);
    check("be_rv_count", 0, 32'(rv_dat[0].size()), 32'd3);
    check("be_merge", 0, rv_dat[0][2], 32'h11BB33DD);

    preload(0, 64);
    rand_phase(0, 300, 64);

    // u1: grant after three held cycles, then stall across the wait
    rv_cyc[1].delete(); rv_dat[1].delete();
    s = cyc;
    do_txn(1, 1'b1, 32'h0, 32'h55, 4'hF, 1'b0, g[0]);
    tick(3);
    check("wait_gnt_cycle", 1, 32'(g[0]), 32'(s + 3));
    check("wait_rv_count", 1, 32'(rv_cyc[1].size()), 32'd1);
    check("wait_rv_cycle", 1, 32'(rv_cyc[1][0]), 32'(s + 5));
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h4; wdata[1] = 32'h77; be[1] = 4'hF;
    for (int k = 7; k <= 11; k++) begin
      stall[1] = (k >= 8 && k <= 10);
      @(negedge clk);
      check("stall_gnt", 1, 32'(gnt[1]), 32'(k == 11));
      @(posedge clk);
      #1;
    end
    req[1] = 1'b0; stall[1] = 1'b0;
    tick(3);
    preload(1, 16);
    rand_phase(1, 150, 16);

    // u2: aliasing across the upper address bits
    rv_cyc[2].delete(); rv_dat[2].delete();
    do_txn(2, 1'b1, 32'h0, 32'h5, 4'hF, 1'b0, g[0]);
    do_txn(2, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0, g[0]);
    tick(3);
    check("alias_rv_count", 2, 32'(rv_dat[2].size()), 32'd2);
    check("alias_rdata", 2, rv_dat[2][1], 32'h5);
    preload(2, 16);
    tick(4);

    // u2: four back-to-back reads against the outstanding limit
    rv_cyc[2].delete(); rv_dat[2].delete();
    max_out[2] = 0;
    s = cyc;
    for (int k = 0; k < 4; k++) do_txn(2, 1'b0, 32'(k) << 2, 32'h0, 4'hF, 1'b0, g[k]);
    tick(3);
    for (int k = 0; k < 4; k++) check("b2b_gnt_cycle", 2, 32'(g[k]), 32'(s + exp_g[k]));
    check("b2b_rv_count", 2, 32'(rv_cyc[2].size()), 32'd4);
    for (int k = 0; k < 4; k++) check("b2b_rv_cycle", 2, 32'(rv_cyc[2][k]), 32'(s + exp_rv[k]));
    check("b2b_max_outstanding", 2, 32'(max_out[2]), 32'd2);

    // u2: reset while two reads are in flight
    tick(2);
    do_txn(2, 1'b0, 32'h8, 32'h0, 4'hF, 1'b0, g[0]);
    do_txn(2, 1'b0, 32'hC, 32'h0, 4'hF, 1'b0, g[1]);
    rst_n[2] = 1'b0;
    req[2] = 1'b1;
    @(negedge clk);
    check("gnt_during_reset", 2, 32'(gnt[2]), 32'h0);
    @(posedge clk);
    #1;
    rst_n[2] = 1'b1;
    req[2] = 1'b0;
    rv_cyc[2].delete(); rv_dat[2].delete();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post_reset_rvalid", 2, 32'(rvalid[2]), 32'h0);
      check("post_reset_outstanding", 2, 32'(outst[2]), 32'h0);
      @(posedge clk);
      #1;
    end
    rand_phase(2, 200, 16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
